// File: rtl/conv_out_pkg.sv
// Shared types and pixel helpers for the convolution output collector.
// Pure declarations: no latency or backpressure of its own.
package conv_out_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    STALL,
    WAITLOW
  } state_t;

  localparam int BORDER_DEFAULT = 2;
  localparam int ROW_W          = 10;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [15:0] dat;
  } fifo_entry_t;

  function automatic logic [15:0] pack_rgb565(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  // BT.601-style weights summing to 256, so the 17-bit sum never exceeds 0xFF00.
  function automatic logic [7:0] luma8(input logic [7:0] r,
                                       input logic [7:0] g,
                                       input logic [7:0] b);
    logic [16:0] acc;
    acc = 17'd77 * {9'd0, r} + 17'd150 * {9'd0, g} + 17'd29 * {9'd0, b};
    return 8'(acc >> 8);
  endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Generic synchronous FIFO with occupancy; write visible at the head one cycle later.
// Writes on full and reads on empty are ignored; head reads as zero while empty.
module conv_out_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 18
) (
  input  logic                    clk_50M,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DW-1:0]           wr_data,
  input  logic                    rd_en,
  output logic [DW-1:0]           rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_wr;
  logic          do_rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/conv_out_collector.sv
// Takes convolved pixels over Load/Load_Comp, drops the warm-up border, packs RGB565 (or Y,Y under GRAYSCALE_OUT_EN) into a FIFO.
// Load_Comp one cycle after Load when space exists; a full FIFO parks the pixel in STALL and withholds Load_Comp.
module conv_out_collector
  import conv_out_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int BORDER = BORDER_DEFAULT,
  parameter int DEPTH  = 16
) (
  input  logic                    clk_50M,
  input  logic                    rst,
  input  logic                    Load,
  input  logic [7:0]              red_pixel,
  input  logic [7:0]              green_pixel,
  input  logic [7:0]              blue_pixel,
  input  logic                    HS,
  input  logic                    frame_start,
  output logic                    Load_Comp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_data,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    stalled
);

  localparam int COL_W = $clog2(WIDTH + 1);
  localparam logic [COL_W-1:0] COL_BORDER = COL_W'(BORDER);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(WIDTH - 1);
  localparam logic [COL_W-1:0] COL_LIMIT  = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] ROW_BORDER = ROW_W'(BORDER);
  localparam logic [ROW_W-1:0] ROW_MAX    = '1;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             sof_pend;
  logic             hs_q;
  logic             hs_fall;
  logic             keep;
  logic             push;
  logic             full;
  logic             empty;
  fifo_entry_t      wr_ent;
  fifo_entry_t      rd_ent;

  assign hs_fall = hs_q && !HS;
  assign keep    = (col >= COL_BORDER) && (row >= ROW_BORDER) && (col < COL_LIMIT);
  // A parked STALL pixel was already judged kept on entry; only space matters now.
  assign push    = !full && ((state == IDLE && Load && keep) || state == STALL);

  always_comb begin
    wr_ent.sof = sof_pend;
    wr_ent.eol = (col == COL_LAST);
`ifdef GRAYSCALE_OUT_EN
    wr_ent.dat = {2{luma8(red_pixel, green_pixel, blue_pixel)}};
`else
    wr_ent.dat = pack_rgb565(red_pixel, green_pixel, blue_pixel);
`endif
  end

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      Load_Comp <= 1'b0;
      stalled   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Load) begin
            if (keep && full) begin
              state   <= STALL;
              stalled <= 1'b1;
            end else begin
              state     <= ACK;
              Load_Comp <= 1'b1;
            end
          end
        end
        STALL: begin
          if (!full) begin
            state     <= ACK;
            Load_Comp <= 1'b1;
            stalled   <= 1'b0;
          end
        end
        ACK: begin
          state     <= WAITLOW;
          Load_Comp <= 1'b0;
        end
        WAITLOW: begin
          if (!Load) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          Load_Comp <= 1'b0;
          stalled   <= 1'b0;
        end
      endcase
    end
  end

  // Frame start beats HS fall, and both beat the ACK column increment.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      col      <= '0;
      row      <= '0;
      sof_pend <= 1'b1;
      hs_q     <= 1'b0;
    end else begin
      hs_q <= HS;
      if (push) sof_pend <= 1'b0;
      if (frame_start) begin
        col      <= '0;
        row      <= '0;
        sof_pend <= 1'b1;
      end else if (hs_fall) begin
        col <= '0;
        if (row != ROW_MAX) row <= row + ROW_W'(1);
      end else if (state == ACK && col != COL_LIMIT) begin
        col <= col + COL_W'(1);
      end
    end
  end

  conv_out_fifo #(
    .DEPTH (DEPTH),
    .DW    ($bits(fifo_entry_t))
  ) u_fifo (
    .clk_50M (clk_50M),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_ent),
    .rd_en   (out_ready),
    .rd_data (rd_ent),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign out_valid = !empty;
  assign out_data  = rd_ent.dat;
  assign out_sof   = rd_ent.sof;
  assign out_eol   = rd_ent.eol;

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector: border drop, packing, stall, eol, frame restart, async reset.
module tb_conv_out_collector;

  logic        clk_50M;
  logic        rst;
  logic        Load;
  logic [7:0]  red_pixel;
  logic [7:0]  green_pixel;
  logic [7:0]  blue_pixel;
  logic        HS;
  logic        frame_start;
  logic        Load_Comp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sof;
  logic        out_eol;
  logic [4:0]  fifo_level;
  logic        stalled;

  int n_checks = 0;
  int n_errors = 0;
  int lc_cnt   = 0;
  int pop_cnt  = 0;
  int eol_cnt  = 0;
  int eol_idx  = -1;
  bit mon_en   = 1'b0;

  conv_out_collector dut (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .Load        (Load),
    .red_pixel   (red_pixel),
    .green_pixel (green_pixel),
    .blue_pixel  (blue_pixel),
    .HS          (HS),
    .frame_start (frame_start),
    .Load_Comp   (Load_Comp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .fifo_level  (fifo_level),
    .stalled     (stalled)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  always @(negedge clk_50M) begin
    if (Load_Comp) lc_cnt++;
    if (mon_en && out_valid && out_ready) begin
      if (out_eol) begin
        eol_cnt++;
        eol_idx = pop_cnt;
      end
      pop_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One upstream handshake; Load_Comp must follow Load by one cycle when space exists.
  task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          output logic vld_ack);
    int lat;
    lat = 0;
    @(negedge clk_50M);
    Load = 1'b1; red_pixel = r; green_pixel = g; blue_pixel = b;
    do begin
      @(negedge clk_50M);
      lat++;
    end while (!Load_Comp && lat < 50);
    vld_ack = out_valid;
    check("ack_latency", lat, 1);
    Load = 1'b0;
    @(negedge clk_50M);
    @(negedge clk_50M);
  endtask

  task automatic hs_pulse_fall();
    @(negedge clk_50M); HS = 1'b0;
    @(negedge clk_50M); HS = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge clk_50M); out_ready = 1'b1;
    @(negedge clk_50M); out_ready = 1'b0;
  endtask

  function automatic logic [15:0] exp_stall(input int i);
    return {5'(i), 6'(i), 5'(20 - i)};
  endfunction

  logic vld;
  int   lc0;

  initial begin
    rst = 1'b0; Load = 1'b0; red_pixel = '0; green_pixel = '0; blue_pixel = '0;
    HS = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk_50M);
    check("rst_load_comp", Load_Comp, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_stalled", stalled, 0);
    rst = 1'b1;

    // Row 0 lies in the warm-up border.
    @(negedge clk_50M); frame_start = 1'b1;
    @(negedge clk_50M); frame_start = 1'b0; HS = 1'b1;
    for (int i = 0; i < 5; i++) send_pix(8'hFF, 8'hFF, 8'hFF, vld);
    check("row0_load_comp_count", lc_cnt, 5);
    check("row0_fifo_level", fifo_level, 0);
    check("row0_out_valid", out_valid, 0);

    // Row 2, columns 0..4: first two dropped.
    hs_pulse_fall();
    hs_pulse_fall();
    send_pix(8'hF8, 8'hFC, 8'hF8, vld);
    send_pix(8'hF8, 8'hFC, 8'hF8, vld);
    check("col1_dropped_valid", vld, 0);
    send_pix(8'hF8, 8'hFC, 8'hF8, vld);
    check("col2_valid_with_ack", vld, 1);
    send_pix(8'hF8, 8'hFC, 8'hF8, vld);
    send_pix(8'hF8, 8'hFC, 8'hF8, vld);
    check("row2_level", fifo_level, 3);
    check("row2_head_data", out_data, 16'hFFFF);
    check("row2_head_sof", out_sof, 1);
    check("row2_head_eol", out_eol, 0);
    pop_one();
    check("row2_second_sof", out_sof, 0);
    check("row2_second_data", out_data, 16'hFFFF);
    check("row2_level_after_pop", fifo_level, 2);
    pop_one();
    pop_one();
    check("row2_drained", out_valid, 0);

    // Fill all 16 entries, then a 17th pixel must stall.
    for (int i = 0; i < 16; i++) send_pix(8'(i << 3), 8'(i << 2), 8'((20 - i) << 3), vld);
    check("fill_level", fifo_level, 16);
    lc0 = lc_cnt;
    @(negedge clk_50M);
    Load = 1'b1; red_pixel = 8'(16 << 3); green_pixel = 8'(16 << 2); blue_pixel = 8'(4 << 3);
    repeat (3) @(negedge clk_50M);
    check("stall_flag", stalled, 1);
    check("stall_no_ack", lc_cnt - lc0, 0);
    check("stall_level", fifo_level, 16);
    check("stall_head", out_data, exp_stall(0));
    out_ready = 1'b1;
    @(negedge clk_50M); out_ready = 1'b0;
    check("stall_after_pop_level", fifo_level, 15);
    check("stall_after_pop_ack", Load_Comp, 0);
    check("stall_after_pop_flag", stalled, 1);
    @(negedge clk_50M);
    check("stall_release_ack", Load_Comp, 1);
    check("stall_release_level", fifo_level, 16);
    check("stall_release_flag", stalled, 0);
    Load = 1'b0;
    repeat (2) @(negedge clk_50M);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_50M);
      check("drain_data", out_data, exp_stall(k));
      out_ready = 1'b1;
    end
    @(negedge clk_50M); out_ready = 1'b0;
    check("drain_empty_level", fifo_level, 0);
    check("drain_empty_valid", out_valid, 0);

    // Load held high long after its acknowledge counts once.
    lc0 = lc_cnt;
    @(negedge clk_50M);
    Load = 1'b1; red_pixel = 8'h10; green_pixel = 8'h20; blue_pixel = 8'h30;
    repeat (12) @(negedge clk_50M);
    Load = 1'b0;
    repeat (2) @(negedge clk_50M);
    check("held_load_one_ack", lc_cnt - lc0, 1);
    check("held_load_one_push", fifo_level, 1);
    check("held_load_data", out_data, 16'h1106);
    pop_one();

    // Full row with free-running sink: only column 319 carries eol.
    hs_pulse_fall();
    @(negedge clk_50M); out_ready = 1'b1; mon_en = 1'b1;
    for (int c = 0; c < 320; c++) send_pix(8'(c), 8'h00, 8'h00, vld);
    repeat (4) @(negedge clk_50M);
    check("row_pop_count", pop_cnt, 318);
    check("row_eol_count", eol_cnt, 1);
    check("row_eol_index", eol_idx, 317);
    send_pix(8'h00, 8'h00, 8'h00, vld);
    repeat (4) @(negedge clk_50M);
    check("col_limit_dropped", pop_cnt, 318);
    hs_pulse_fall();
    for (int c = 0; c < 3; c++) send_pix(8'h00, 8'h00, 8'h00, vld);
    repeat (4) @(negedge clk_50M);
    check("new_row_col_reset", pop_cnt, 319);
    check("new_row_eol_count", eol_cnt, 1);
    @(negedge clk_50M); out_ready = 1'b0; mon_en = 1'b0;

    // Frame restart: border again, then sof on first kept pixel.
    @(negedge clk_50M); frame_start = 1'b1;
    @(negedge clk_50M); frame_start = 1'b0;
    for (int c = 0; c < 3; c++) send_pix(8'h08, 8'h04, 8'h08, vld);
    check("frame_row0_dropped", fifo_level, 0);
    hs_pulse_fall();
    hs_pulse_fall();
    for (int c = 0; c < 3; c++) send_pix(8'h08, 8'h04, 8'h08, vld);
    check("frame_level", fifo_level, 1);
    check("frame_sof", out_sof, 1);
    check("frame_data", out_data, 16'h0821);

    // Asynchronous reset while Load_Comp is high.
    @(negedge clk_50M); Load = 1'b1;
    @(negedge clk_50M);
    check("pre_reset_ack", Load_Comp, 1);
    rst = 1'b0;
    #1;
    check("async_rst_ack", Load_Comp, 0);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_valid", out_valid, 0);
    Load = 1'b0;
    repeat (2) @(negedge clk_50M);
    rst = 1'b1;
    repeat (2) @(negedge clk_50M);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
